gate_alu_fifo: RTL and testbench
================================

GATE_ALU_FIFO -- requirements
Module: gate_alu_fifo

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4: result buffer entries; power of two, 2..64.
REQ-003 Parameter CNT_W, default 16: width of the delivered-result counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set on a, b, op is valid.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 op  input  3  gate select, sampled with the operands.
REQ-011 out_valid  output  1  y and y_any hold a buffered result.
REQ-012 out_ready  input  1  consumer takes the head result this cycle.
REQ-013 y  output  WIDTH  head result.
REQ-014 y_any  output  1  reduction OR of the head result.
REQ-015 count  output  CNT_W  number of results delivered since reset, modulo 2^CNT_W.

Function
REQ-016 The input handshake SHALL complete on a rising edge where in_valid=1 and in_ready=1; the output handshake SHALL complete on a rising edge where out_valid=1 and out_ready=1.
REQ-017 The op encoding SHALL be bitwise: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 pass a (b ignored).
REQ-018 The result SHALL be computed from a, b and op as sampled at input handshake and written into a DEPTH-entry FIFO in the same edge.
REQ-019 The FIFO SHALL preserve order; the head entry SHALL drive y and y_any directly from storage (registered, no combinational path from a, b or op).
REQ-020 Latency SHALL be one cycle: with the FIFO empty, a result accepted at edge N SHALL show out_valid=1 and the correct y after edge N.
REQ-021 in_ready SHALL equal NOT full and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL equal NOT empty.
REQ-023 When full, no write SHALL occur even if out_ready=1 in the same cycle; the FIFO accepts again on the following cycle.
REQ-024 A simultaneous write and read while neither full nor empty SHALL leave occupancy unchanged.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication.
REQ-026 While out_valid=0, out_ready SHALL have no effect; while in_ready=0, in_valid SHALL have no effect.
REQ-027 count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 y and y_any SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 When empty, y SHALL read all-zero and y_any SHALL read 0.

Reset
REQ-030 While rst_n=0 the block SHALL force: FIFO empty, pointers 0, in_ready=1, out_valid=0, y=0, y_any=0, count=0, independent of clk.
REQ-031 Assertion of rst_n mid-operation SHALL discard all buffered results immediately; contents are not recoverable.
REQ-032 The first input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 WIDTH=8: a=0x0F, b=0x33, ops 000..111 back-to-back with out_ready=1 -> y = 0x03, 0x3F, 0xFC, 0xC0, 0x3C, 0xC3, 0xF0, 0x0F, each one cycle after acceptance; count=8.
REQ-034 DEPTH=4, out_ready=0, five operand sets presented -> first four accepted, in_ready=0 after the fourth; fifth held; y stays at first result.
REQ-035 Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> one read, no write; next cycle the fifth set is accepted; order preserved.
REQ-036 Continuous streaming, in_valid=out_ready=1 for 20 cycles -> 20 results in order, pointers wrap repeatedly, occupancy constant at 1 after start-up.
REQ-037 rst_n pulsed low asynchronously with 3 entries buffered -> out_valid=0, count=0, y=0 before the next clk edge; a subsequent op=011, a=0x00, b=0x00 yields y=0xFF, y_any=1.
REQ-038 CNT_W=4: 17 output handshakes -> count reads 1.

Source files
------------

// File: rtl/gate_alu_fifo.sv
// gate_alu_fifo: bitwise gate ALU whose results queue in an ordered FIFO
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/op operand handshake;
// out_valid/out_ready/y/y_any head-result handshake; count = results delivered since reset.
module gate_alu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_any,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] P_ONE = 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] w_res;
   logic             w_empty;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;
   // pointers carry one extra wrap bit so full and empty are distinguishable
   assign w_empty   = r_wr == r_rd;
   assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_wr      = in_valid && !w_full;
   assign w_rd      = out_ready && !w_empty;
   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign y         = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
   assign y_any     = |y;
   assign count     = r_count;
   always_comb begin
      w_res = '0;
      case (op)
         3'b000: w_res = a & b;
         3'b001: w_res = a | b;
         3'b010: w_res = ~(a & b);
         3'b011: w_res = ~(a | b);
         3'b100: w_res = a ^ b;
         3'b101: w_res = ~(a ^ b);
         3'b110: w_res = ~a;
         3'b111: w_res = a;
      endcase
   end
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr[AW-1:0]] <= w_res;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wr <= r_wr + P_ONE;
         if (w_rd) begin
            r_rd    <= r_rd + P_ONE;
            r_count <= r_count + CNT_W'(1);
         end
      end
endmodule

// File: tb/tb_gate_alu_fifo.sv
// tb_gate_alu_fifo: directed scoreboard bench for gate_alu_fifo (default and CNT_W=4 instances)
module tb_gate_alu_fifo;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic [2:0]  op = '0;
   logic        in_ready, out_valid, y_any, in_ready1, out_valid1, y_any1;
   logic [7:0]  y, y1;
   logic [15:0] count;
   logic [3:0]  count1;
   logic [7:0]  q[$];
   logic [15:0] m_cnt = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   gate_alu_fifo u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_any(y_any), .count(count)
   );

   gate_alu_fifo #(.CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
      .y(y1), .y_any(y_any1), .count(count1)
   );

   function automatic logic [7:0] gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      case (o)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return ~(x & z);
         3'd3:    return ~(x | z);
         3'd4:    return x ^ z;
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare every output against the scoreboard, then advance one clock
   task automatic cyc();
      logic [7:0] h;
      logic       ih, oh;
      h  = (q.size() != 0) ? q[0] : 8'h00;
      ih = in_valid && (q.size() < 4);
      oh = out_ready && (q.size() != 0);
      chk("in_ready", in_ready, q.size() < 4);
      chk("out_valid", out_valid, q.size() != 0);
      chk("y", y, h);
      chk("y_any", y_any, |h);
      chk("count", count, m_cnt);
      chk("in_ready1", in_ready1, q.size() < 4);
      chk("out_valid1", out_valid1, q.size() != 0);
      chk("y1", y1, h);
      chk("y_any1", y_any1, |h);
      chk("count1", count1, m_cnt[3:0]);
      if (oh) begin
         h = q.pop_front();
         m_cnt++;
      end
      if (ih) q.push_back(gate(op, a, b));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] k [8];
      k = '{8'h03, 8'h3F, 8'hFC, 8'hC0, 8'h3C, 8'hC3, 8'hF0, 8'h0F};
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_y", y, 8'h00);
      chk("rst_y_any", y_any, 1'b0);
      chk("rst_count", count, 16'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // all eight gates back to back, draining continuously
      a = 8'h0F; b = 8'h33; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         cyc();
         chk("ops_y", y, k[i]);
      end
      in_valid = 1'b0;
      cyc();
      chk("ops_count", count, 16'd8);
      // fill with the consumer stalled
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = 8'(8'h11 * (i + 1)); b = 8'(8'hF0 ^ i); op = 3'(i + 2);
         cyc();
      end
      chk("full_in_ready", in_ready, 1'b0);
      a = 8'hAA; b = 8'h55; op = 3'd4;
      cyc();
      cyc();
      chk("full_head", y, gate(3'd2, 8'h11, 8'hF0));
      // read while full: no write this cycle, fifth accepted next
      out_ready = 1'b1;
      cyc();
      chk("full_rd_in_ready", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      repeat (5) cyc();
      chk("drained", out_valid, 1'b0);
      // streaming, wraps pointers many times
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("stream_count", count, 16'd33);
      // async reset with three entries buffered
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_y", y, 8'h00);
      chk("arst_y_any", y_any, 1'b0);
      chk("arst_count", count, 16'd0);
      chk("arst_count1", count1, 4'd0);
      q.delete();
      m_cnt = '0;
      rst_n = 1'b1;
      a = 8'h00; b = 8'h00; op = 3'b011; in_valid = 1'b1;
      cyc();
      chk("post_rst_y", y, 8'hFF);
      chk("post_rst_y_any", y_any, 1'b1);
      // 17 deliveries: 4-bit counter wraps to 1
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("wrap_count1", count1, 4'd1);
      chk("wrap_count", count, 16'd17);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
